flag_sequencer: RTL

FLAG_SEQUENCER -- requirements
Module: flag_sequencer

---
 rtl/flag_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/flag_sequencer.sv
// Flag-register sequencer: maps instruction flag classes to update selects and
// saves/restores {N,Z,C,V,M} on a small LIFO around software interrupts and returns.
module flag_sequencer #(
    parameter int DEPTH = 4,
    parameter int PW    = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     instr_valid,
    input  logic [2:0]               flag_op,
    input  logic                     swi_req,
    input  logic                     ret_req,
    input  logic [4:0]               cur_flags,
    output logic [PW-1:0]            update_mode,
    output logic                     spec_enable,
    output logic                     restore_valid,
    output logic [4:0]               restore_flags,
    output logic                     exc_ack,
    output logic                     ret_ack,
    output logic                     ret_err,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     fault
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_FULL  = (AW+1)'(DEPTH);
    localparam logic [PW-1:0] MODE_NONE   = '0;
    localparam logic [PW-1:0] MODE_TOGGLE = PW'(3'd5);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SAVE    = 3'd1,
        TOGGLE  = 3'd2,
        RESTORE = 3'd3,
        FAULT   = 3'd4
    } state_e;

    state_e          state_q;
    logic [PW-1:0]   update_mode_q;
    logic            spec_enable_q;
    logic            restore_valid_q;
    logic [4:0]      restore_flags_q;
    logic            exc_ack_q;
    logic            ret_ack_q;
    logic            ret_err_q;
    logic [AW:0]     depth_q;
    logic            fault_q;
    logic [AW-1:0]   wr_ptr_q;

    logic [AW-1:0]   wr_ptr_inc_d;
    logic [AW-1:0]   top_ptr_d;
    logic [PW-1:0]   op_mode_d;
    logic            stack_full;
    logic            stack_empty;

    logic [4:0]      stack_mem [DEPTH];

    // Pointers wrap naturally modulo DEPTH; occupancy alone tells full from empty.
    assign wr_ptr_inc_d = wr_ptr_q + AW'(1);
    assign top_ptr_d    = wr_ptr_q - AW'(1);
    assign stack_full   = (depth_q == DEPTH_FULL);
    assign stack_empty  = (depth_q == '0);

    always_comb begin
        op_mode_d = MODE_NONE;
        case (flag_op)
            3'd1, 3'd2, 3'd3, 3'd4: op_mode_d = PW'(flag_op);
            default:                op_mode_d = MODE_NONE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (state_q == SAVE) begin
            stack_mem[wr_ptr_q] <= cur_flags;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= RUN;
            update_mode_q   <= MODE_NONE;
            spec_enable_q   <= 1'b1;
            restore_valid_q <= 1'b0;
            restore_flags_q <= '0;
            exc_ack_q       <= 1'b0;
            ret_ack_q       <= 1'b0;
            ret_err_q       <= 1'b0;
            depth_q         <= '0;
            fault_q         <= 1'b0;
            wr_ptr_q        <= '0;
        end else begin
            update_mode_q   <= MODE_NONE;
            restore_valid_q <= 1'b0;
            exc_ack_q       <= 1'b0;
            ret_ack_q       <= 1'b0;
            ret_err_q       <= 1'b0;
            case (state_q)
                RUN: begin
                    if (!stall) begin
                        if (swi_req) begin
                            if (stack_full) begin
                                state_q       <= FAULT;
                                fault_q       <= 1'b1;
                                spec_enable_q <= 1'b0;
                            end else begin
                                state_q <= SAVE;
                            end
                        end else if (ret_req) begin
                            if (stack_empty) begin
                                ret_err_q <= 1'b1;
                            end else begin
                                // Pop on entry so the strobes are visible while in RESTORE,
                                // letting the requester drop ret_req before RUN resamples it.
                                state_q         <= RESTORE;
                                restore_flags_q <= stack_mem[top_ptr_d];
                                restore_valid_q <= 1'b1;
                                ret_ack_q       <= 1'b1;
                                wr_ptr_q        <= top_ptr_d;
                                depth_q         <= depth_q - (AW+1)'(1);
                            end
                        end else if (instr_valid) begin
                            update_mode_q <= op_mode_d;
                        end
                    end
                end
                SAVE: begin
                    wr_ptr_q      <= wr_ptr_inc_d;
                    depth_q       <= depth_q + (AW+1)'(1);
                    update_mode_q <= MODE_TOGGLE;
                    exc_ack_q     <= 1'b1;
                    state_q       <= TOGGLE;
                end
                TOGGLE:  state_q <= RUN;
                RESTORE: state_q <= RUN;
                FAULT:   state_q <= FAULT;
                default: state_q <= RUN;
            endcase
        end
    end

    assign update_mode   = update_mode_q;
    assign spec_enable   = spec_enable_q;
    assign restore_valid = restore_valid_q;
    assign restore_flags = restore_flags_q;
    assign exc_ack       = exc_ack_q;
    assign ret_ack       = ret_ack_q;
    assign ret_err       = ret_err_q;
    assign depth         = depth_q;
    assign fault         = fault_q;

endmodule
